conv_transpose_layer: RTL and testbench

CONV_TRANSPOSE_LAYER -- requirements
Module: conv_transpose_layer

---
 rtl/conv_transpose_layer.sv | 194 +++++++++++++++++++
 tb/tb_conv_transpose_layer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_transpose_layer.sv
// Streaming transposed convolution: scatters each input pixel through the kernel into an
// output-sized accumulator bank, then drains it in raster order. Optional clamp: CONV_TRANSPOSE_SATURATE_EN.
module conv_transpose_layer #(
  parameter int INPUT_SIZE     = 3,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PX_SIZE-1:0] kernel [KERNEL_SIZE][KERNEL_SIZE][INPUT_CHANNELS],
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PX_SIZE-1:0] in_px [INPUT_CHANNELS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PX_SIZE-1:0] out_px,
  output logic               out_last
);

  localparam int OUTPUT_SIZE = INPUT_SIZE + KERNEL_SIZE - 1;
  localparam int ACC_SIZE    = 2*PX_SIZE + $clog2(KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS);
  localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ACCEPT  = 2'd1,
    SCATTER = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t              state_r;
  logic [ACC_SIZE-1:0] acc_r [OUTPUT_SIZE][OUTPUT_SIZE];
  logic [PX_SIZE-1:0]  px_r [INPUT_CHANNELS];
  logic [IW-1:0]       pix_row_r, pix_col_r, cur_row_r, cur_col_r;
  logic                last_px_r;
  logic [KW-1:0]       ky_r, kx_r;
  logic [OW-1:0]       out_row_r, out_col_r;
  logic                in_ready_r, out_valid_r, out_last_r;
  logic [PX_SIZE-1:0]  out_px_r;

  logic [ACC_SIZE-1:0] dot_s, sum_s;
  logic [OW-1:0]       tgt_row_s, tgt_col_s, nxt_row_s, nxt_col_s;
  logic                nxt_last_s;
  logic [PX_SIZE-1:0]  first_px_s;

  function automatic logic [PX_SIZE-1:0] to_px(input logic [ACC_SIZE-1:0] a);
`ifdef CONV_TRANSPOSE_SATURATE_EN
    if (|a[ACC_SIZE-1:PX_SIZE]) begin
      to_px = {PX_SIZE{1'b1}};
    end else begin
      to_px = a[PX_SIZE-1:0];
    end
`else
    to_px = PX_SIZE'(a);
`endif
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_px    = out_px_r;
  assign out_last  = out_last_r;

  // Channel dot product for the current kernel tap and the accumulator it lands in
  always_comb begin
    dot_s = {ACC_SIZE{1'b0}};
    for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
      dot_s = dot_s + ACC_SIZE'(px_r[ch]) * ACC_SIZE'(kernel[ky_r][kx_r][ch]);
    end
    tgt_row_s = OW'(cur_row_r) + OW'(ky_r);
    tgt_col_s = OW'(cur_col_r) + OW'(kx_r);
    sum_s     = acc_r[tgt_row_s][tgt_col_s] + dot_s;
  end

  // First drain beat; forwards the final scatter write when it hits cell (0,0)
  always_comb begin
    if ((tgt_row_s == {OW{1'b0}}) && (tgt_col_s == {OW{1'b0}})) begin
      first_px_s = to_px(sum_s);
    end else begin
      first_px_s = to_px(acc_r[0][0]);
    end
  end

  // Raster successor of the beat currently presented
  always_comb begin
    if (out_col_r == OW'(OUTPUT_SIZE - 1)) begin
      nxt_col_s = {OW{1'b0}};
      nxt_row_s = out_row_r + OW'(1'b1);
    end else begin
      nxt_col_s = out_col_r + OW'(1'b1);
      nxt_row_s = out_row_r;
    end
    nxt_last_s = (nxt_row_s == OW'(OUTPUT_SIZE - 1)) && (nxt_col_s == OW'(OUTPUT_SIZE - 1));
  end

  // Control FSM, accumulator bank and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_px_r    <= {PX_SIZE{1'b0}};
      out_last_r  <= 1'b0;
      pix_row_r   <= {IW{1'b0}};
      pix_col_r   <= {IW{1'b0}};
      cur_row_r   <= {IW{1'b0}};
      cur_col_r   <= {IW{1'b0}};
      last_px_r   <= 1'b0;
      ky_r        <= {KW{1'b0}};
      kx_r        <= {KW{1'b0}};
      out_row_r   <= {OW{1'b0}};
      out_col_r   <= {OW{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          for (int r = 0; r < OUTPUT_SIZE; r++) begin
            for (int c = 0; c < OUTPUT_SIZE; c++) begin
              acc_r[r][c] <= {ACC_SIZE{1'b0}};
            end
          end
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          pix_row_r   <= {IW{1'b0}};
          pix_col_r   <= {IW{1'b0}};
          state_r     <= ACCEPT;
        end
        ACCEPT: begin
          if (in_valid && in_ready_r) begin
            px_r       <= in_px;
            cur_row_r  <= pix_row_r;
            cur_col_r  <= pix_col_r;
            last_px_r  <= (pix_row_r == IW'(INPUT_SIZE - 1)) && (pix_col_r == IW'(INPUT_SIZE - 1));
            if (pix_col_r == IW'(INPUT_SIZE - 1)) begin
              pix_col_r <= {IW{1'b0}};
              pix_row_r <= pix_row_r + IW'(1'b1);
            end else begin
              pix_col_r <= pix_col_r + IW'(1'b1);
            end
            ky_r       <= {KW{1'b0}};
            kx_r       <= {KW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= SCATTER;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SCATTER: begin
          acc_r[tgt_row_s][tgt_col_s] <= sum_s;
          if (kx_r != KW'(KERNEL_SIZE - 1)) begin
            kx_r <= kx_r + KW'(1'b1);
          end else if (ky_r != KW'(KERNEL_SIZE - 1)) begin
            kx_r <= {KW{1'b0}};
            ky_r <= ky_r + KW'(1'b1);
          end else if (last_px_r) begin
            out_row_r   <= {OW{1'b0}};
            out_col_r   <= {OW{1'b0}};
            out_px_r    <= first_px_s;
            out_last_r  <= (OUTPUT_SIZE == 1);
            out_valid_r <= 1'b1;
            state_r     <= DRAIN;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= ACCEPT;
          end
        end
        DRAIN: begin
          if (out_ready && out_last_r) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_px_r    <= {PX_SIZE{1'b0}};
            state_r     <= CLEAR;
          end else if (out_ready) begin
            out_row_r  <= nxt_row_s;
            out_col_r  <= nxt_col_s;
            out_px_r   <= to_px(acc_r[nxt_row_s][nxt_col_s]);
            out_last_r <= nxt_last_s;
          end else begin
            out_px_r   <= out_px_r;
            out_last_r <= out_last_r;
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_transpose_layer.sv
// Bench for conv_transpose_layer: directed and random frames against a direct-sum reference.
module tb_conv_transpose_layer;
  localparam int IS = 3, C = 3, K = 3, PX = 8;
  localparam int OS = IS + K - 1, NB = OS * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PX-1:0] kernel [K][K][C];
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PX-1:0] in_px [C];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PX-1:0] out_px;
  logic          out_last;

  int tests = 0, fails = 0;
  int img [IS][IS][C];
  int beats[$];
  bit lasts[$];

  always #5 clk = ~clk;

  conv_transpose_layer #(.INPUT_SIZE(IS), .INPUT_CHANNELS(C), .KERNEL_SIZE(K), .PX_SIZE(PX)) dut (
    .clk(clk), .rst(rst), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .in_px(in_px),
    .out_valid(out_valid), .out_ready(out_ready), .out_px(out_px), .out_last(out_last)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output pixel b as the plain sum over every (input pixel, kernel tap) pair landing on it
  function automatic int model(input int b);
    int r, c, ky, kx;
    longint s;
    r = b / OS; c = b % OS; s = 0;
    for (int iy = 0; iy < IS; iy++)
      for (int ix = 0; ix < IS; ix++) begin
        ky = r - iy; kx = c - ix;
        if (ky >= 0 && ky < K && kx >= 0 && kx < K)
          for (int ch = 0; ch < C; ch++) s += img[iy][ix][ch] * int'(kernel[ky][kx][ch]);
      end
`ifdef CONV_TRANSPOSE_SATURATE_EN
    return (s > 255) ? 255 : int'(s);
`else
    return int'(s % 256);
`endif
  endfunction

  task automatic fill_const(input int iv, input int kv);
    for (int y = 0; y < IS; y++) for (int x = 0; x < IS; x++) for (int ch = 0; ch < C; ch++) img[y][x][ch] = iv;
    for (int y = 0; y < K; y++) for (int x = 0; x < K; x++) for (int ch = 0; ch < C; ch++) kernel[y][x][ch] = PX'(kv);
  endtask

  task automatic fill_impulse();
    fill_const(0, 0);
    img[1][1][0] = 5;
    for (int y = 0; y < K; y++) for (int x = 0; x < K; x++) kernel[y][x][0] = PX'(3*y + x + 1);
  endtask

  task automatic fill_random();
    for (int y = 0; y < IS; y++) for (int x = 0; x < IS; x++) for (int ch = 0; ch < C; ch++) img[y][x][ch] = int'($urandom_range(0, 255));
    for (int y = 0; y < K; y++) for (int x = 0; x < K; x++) for (int ch = 0; ch < C; ch++) kernel[y][x][ch] = PX'($urandom_range(0, 255));
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_px", out_px, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("ready_after_edge1", in_ready, 0);
    @(negedge clk); check("ready_after_edge2", in_ready, 1);
  endtask

  // Offer npix pixels of img in raster order; gaps randomly drop in_valid
  task automatic send_frame(input bit gaps, input int npix);
    int idx = 0, cyc = 0, busy = 0, last_acc = -1, vr = 0, vb = 0, vt = 0;
    while (idx < npix && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (busy > 0) begin
        if (in_ready) vr++;
        busy--;
      end
      if (in_ready && out_valid) vb++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int ch = 0; ch < C; ch++) in_px[ch] = PX'(img[idx / IS][idx % IS][ch]);
      if (in_valid && in_ready) begin
        if (!gaps && last_acc >= 0 && (cyc - last_acc) != K*K + 1) vt++;
        last_acc = cyc; idx++; busy = K*K;
      end
    end
    check("accepted_pixels", idx, npix);
    check("ready_during_scatter", vr, 0);
    check("ready_and_valid", vb, 0);
    check("input_throughput", vt, 0);
  endtask

  // Collect one output frame; mode 0 always ready, 1 alternating, 2 random
  task automatic recv_frame(input int mode);
    int cyc = 0, vr = 0, vh = 0, nlast = 0, vcmp = 0;
    bit stalled = 1'b0, done = 1'b0;
    logic [PX-1:0] held_px;
    logic held_last;
    beats.delete(); lasts.delete();
    while (!done && cyc < 2000) begin
      @(negedge clk); cyc++;
      in_valid = 1'b0;
      if (in_ready) vr++;
      if (stalled && (out_px !== held_px || out_last !== held_last)) vh++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2) == 1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        beats.push_back(int'(out_px)); lasts.push_back(out_last);
        if (out_last) done = 1'b1;
      end else if (out_valid) begin
        stalled = 1'b1; held_px = out_px; held_last = out_last;
      end
    end
    @(negedge clk); out_ready = 1'b0;
    check("beat_count", beats.size(), NB);
    for (int b = 0; b < beats.size(); b++) begin
      if (beats[b] != model(b)) begin
        vcmp++;
        $display("  beat %0d got %0d model %0d", b, beats[b], model(b));
      end
      if (lasts[b]) nlast++;
    end
    check("beats_vs_model", vcmp, 0);
    check("last_count", nlast, 1);
    check("last_on_final", (lasts.size() == NB) ? int'(lasts[NB-1]) : -1, 1);
    check("ready_during_drain", vr, 0);
    check("stall_hold", vh, 0);
  endtask

  task automatic ones_constants(input string tag);
    check({tag, "_out00"}, beats[0], 3);
    check({tag, "_out02"}, beats[2], 9);
    check({tag, "_out22"}, beats[12], 27);
    check({tag, "_out44"}, beats[24], 3);
  endtask

  initial begin
    for (int ch = 0; ch < C; ch++) in_px[ch] = '0;
    fill_const(0, 0);
    apply_reset();

    fill_const(1, 1);
    send_frame(1'b0, IS*IS); recv_frame(0);
    ones_constants("ones");

    fill_impulse();
    send_frame(1'b0, IS*IS); recv_frame(0);
    check("impulse_out33", beats[18], 45);
    check("impulse_out11", beats[6], 5);
    check("impulse_out00", beats[0], 0);

    fill_const(255, 255);
    send_frame(1'b0, IS*IS); recv_frame(0);
`ifdef CONV_TRANSPOSE_SATURATE_EN
    check("max_out22", beats[12], 255);
    check("max_out00", beats[0], 255);
`else
    // each 255*255 product is 1 mod 256; cell (2,2) collects 27 of them
    check("max_out22", beats[12], 27);
    check("max_out00", beats[0], 3);
`endif

    fill_const(1, 1);
    send_frame(1'b0, IS*IS); recv_frame(1);
    ones_constants("stall");

    fill_const(7, 9);
    send_frame(1'b0, 4);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    apply_reset();
    fill_const(1, 1);
    send_frame(1'b0, IS*IS); recv_frame(0);
    ones_constants("post_reset");

    for (int n = 0; n < 3; n++) begin
      fill_random();
      send_frame(1'b1, IS*IS); recv_frame(2);
    end

    fill_const(1, 1);
    send_frame(1'b1, IS*IS); recv_frame(2);
    ones_constants("gaps");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
